servo_loop_sequencer: RTL

// - Schedules one closed-loop servo sample: periodic tick -> ADC SPI conversion -> IPD update -> pipeline flush -> PWM register load.
// - Replaces free-running CS generation and data-ready gating with one FSM, so every stage fires exactly once per sample period.
// - Sits between the SPI ADC master, the IPD controller, the pipeline registers and the PWM output register.
// - Adds overrun and timeout detection.

---
 rtl/servo_pkg.sv | 31 +++
 rtl/servo_tick_gen.sv | 41 ++++
 rtl/servo_loop_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the servo loop sequencer: state codes, widths and a
// counter-width helper.
package servo_pkg;

  localparam int SAMPLE_COUNT_W = 16;
  localparam int STATE_W        = 3;

  localparam logic [STATE_W-1:0] S_IDLE_CODE      = 3'd0;
  localparam logic [STATE_W-1:0] S_WAIT_TICK_CODE = 3'd1;
  localparam logic [STATE_W-1:0] S_CONVERT_CODE   = 3'd2;
  localparam logic [STATE_W-1:0] S_WAIT_ADC_CODE  = 3'd3;
  localparam logic [STATE_W-1:0] S_COMPUTE_CODE   = 3'd4;
  localparam logic [STATE_W-1:0] S_PIPE_CODE      = 3'd5;
  localparam logic [STATE_W-1:0] S_LOAD_CODE      = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = S_IDLE_CODE,
    ST_WAIT_TICK = S_WAIT_TICK_CODE,
    ST_CONVERT   = S_CONVERT_CODE,
    ST_WAIT_ADC  = S_WAIT_ADC_CODE,
    ST_COMPUTE   = S_COMPUTE_CODE,
    ST_PIPE      = S_PIPE_CODE,
    ST_LOAD      = S_LOAD_CODE
  } state_t;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Sample-period divider: counts 0..SAMPLE_DIV-1 while enabled, holds at 0
// otherwise, and pulses sample_tick while the count sits at its last value.
module servo_tick_gen
  import servo_pkg::*;
#(
  parameter int SAMPLE_DIV = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic sample_tick
);

  localparam int DIV_W = cnt_width(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  always_comb begin
    div_d = '0;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
    // Registered pulse that lines up with the cycle the count holds DIV_LAST.
    tick_d = enable && (div_d == DIV_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign sample_tick = tick_q;

endmodule

// File: rtl/servo_loop_sequencer.sv
// One-sample-per-period servo scheduler: tick -> ADC conversion -> IPD update
// -> pipeline flush -> PWM load, with sticky overrun/timeout detection.
module servo_loop_sequencer
  import servo_pkg::*;
#(
  parameter int SAMPLE_DIV  = 500_000,
  parameter int CS_PULSE    = 138,
  parameter int ADC_TIMEOUT = 4096,
  parameter int PIPE_DEPTH  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear_flags,
  input  logic                      adc_busy,
  input  logic                      adc_ready,
  output logic                      adc_start,
  output logic                      ipd_en,
  output logic                      pwm_load,
  output logic                      sample_tick,
  output logic [SAMPLE_COUNT_W-1:0] sample_count,
  output logic                      overrun,
  output logic                      timeout,
  output logic [STATE_W-1:0]        state_dbg
);

  localparam int CS_W = cnt_width(CS_PULSE);
  localparam int TO_W = cnt_width(ADC_TIMEOUT);
  localparam int PD_W = cnt_width(PIPE_DEPTH);

  localparam logic [CS_W-1:0] CS_LAST = CS_W'(CS_PULSE - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ADC_TIMEOUT - 1);
  localparam logic [PD_W-1:0] PD_LAST = PD_W'(PIPE_DEPTH - 1);

  state_t                    state_q, state_d;
  logic [CS_W-1:0]           cs_cnt_q, cs_cnt_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic [PD_W-1:0]           pipe_cnt_q, pipe_cnt_d;
  logic                      ready_lat_q, ready_lat_d;
  logic                      overrun_q, overrun_d;
  logic                      timeout_q, timeout_d;
  logic [SAMPLE_COUNT_W-1:0] count_q, count_d;
  logic                      adc_start_q, adc_start_d;
  logic                      ipd_en_q, ipd_en_d;
  logic                      pwm_load_q, pwm_load_d;
  logic                      tick;
  logic                      overrun_set;
  logic                      timeout_set;

  servo_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick_gen (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sample_tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    cs_cnt_d    = cs_cnt_q;
    to_cnt_d    = to_cnt_q;
    pipe_cnt_d  = pipe_cnt_q;
    ready_lat_d = ready_lat_q;
    overrun_set = 1'b0;
    timeout_set = 1'b0;

    // A tick landing mid-sequence is flagged but never interrupts the sample.
    if (tick && (state_q != ST_IDLE) && (state_q != ST_WAIT_TICK)) begin
      overrun_set = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT_TICK;
        end
      end
      ST_WAIT_TICK: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (adc_busy) begin
            overrun_set = 1'b1;
          end else begin
            state_d  = ST_CONVERT;
            cs_cnt_d = '0;
          end
        end
      end
      ST_CONVERT: begin
        if (adc_ready) begin
          ready_lat_d = 1'b1;
        end
        if (cs_cnt_q == CS_LAST) begin
          state_d  = ST_WAIT_ADC;
          to_cnt_d = '0;
        end else begin
          cs_cnt_d = cs_cnt_q + 1'b1;
        end
      end
      ST_WAIT_ADC: begin
        ready_lat_d = 1'b0;
        // A ready arriving on the final timeout cycle still completes the sample.
        if (adc_ready || ready_lat_q) begin
          state_d = ST_COMPUTE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_set = 1'b1;
          state_d     = ST_WAIT_TICK;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_COMPUTE: begin
        state_d    = ST_PIPE;
        pipe_cnt_d = '0;
      end
      ST_PIPE: begin
        if (pipe_cnt_q == PD_LAST) begin
          state_d = ST_LOAD;
        end else begin
          pipe_cnt_d = pipe_cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT_TICK;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    // Strobes are decoded from the next state so each flop mirrors state_q.
    adc_start_d = (state_d == ST_CONVERT);
    ipd_en_d    = (state_d == ST_COMPUTE);
    pwm_load_d  = (state_d == ST_LOAD);
    count_d     = pwm_load_d ? count_q + 1'b1 : count_q;

    overrun_d = overrun_q;
    if (clear_flags) begin
      overrun_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end

    timeout_d = timeout_q;
    if (clear_flags) begin
      timeout_d = 1'b0;
    end
    if (timeout_set) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cs_cnt_q    <= '0;
      to_cnt_q    <= '0;
      pipe_cnt_q  <= '0;
      ready_lat_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
      adc_start_q <= 1'b0;
      ipd_en_q    <= 1'b0;
      pwm_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_cnt_q    <= cs_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pipe_cnt_q  <= pipe_cnt_d;
      ready_lat_q <= ready_lat_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      count_q     <= count_d;
      adc_start_q <= adc_start_d;
      ipd_en_q    <= ipd_en_d;
      pwm_load_q  <= pwm_load_d;
    end
  end

  assign adc_start    = adc_start_q;
  assign ipd_en       = ipd_en_q;
  assign pwm_load     = pwm_load_q;
  assign sample_tick  = tick;
  assign sample_count = count_q;
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;
  assign state_dbg    = state_q;

endmodule
